// File: rtl/phased_array_driver_if.sv
// Configuration bus between the host-command decoder and the phased array driver.
// The decoder is the master: it issues register writes and commit requests and
// observes the pending/error status returned by the driver.
interface phased_array_driver_if #(
    parameter int ADDR_W = 7,
    parameter int DATA_W = 16
);
    logic              cfg_we;
    logic [ADDR_W-1:0] cfg_addr;
    logic [DATA_W-1:0] cfg_data;
    logic              cfg_commit;
    logic              commit_pending;
    logic              cfg_err;

    modport master (
        output cfg_we, cfg_addr, cfg_data, cfg_commit,
        input  commit_pending, cfg_err
    );

    modport slave (
        input  cfg_we, cfg_addr, cfg_data, cfg_commit,
        output commit_pending, cfg_err
    );
endinterface

// File: rtl/phased_array_driver.sv
// Multi-channel square-wave generator for the transducer array.
// One shared period counter feeds NUM_CH channels, each with its own phase
// offset and a 50% duty cycle. Host writes land in shadow registers and are
// copied to the active set only at a period boundary (or at once while idle),
// so retuning never produces a glitch on the channel pins.
module phased_array_driver #(
    parameter int NUM_CH     = 10,
    parameter int CNT_W      = 16,
    parameter int DEF_PERIOD = 2500,
    parameter int ADDR_W     = 7
) (
    input  logic                  clk_100MHz,
    input  logic                  RSTN,
    input  logic                  run,
    phased_array_driver_if.slave  cfg,
    output logic                  sync,
    output logic [NUM_CH-1:0]     ch_out
);

    localparam logic [CNT_W-1:0]  DEF_P     = CNT_W'(DEF_PERIOD);
    localparam logic [CNT_W-1:0]  MIN_P     = CNT_W'(2);
    localparam logic [ADDR_W-1:0] MASK_ADDR = ADDR_W'(NUM_CH + 1);

    logic [CNT_W-1:0]  cnt;
    logic [CNT_W-1:0]  period_act;
    logic [CNT_W-1:0]  period_sh;
    logic [CNT_W-1:0]  new_period;
    logic [CNT_W-1:0]  phase_act [NUM_CH];
    logic [CNT_W-1:0]  phase_sh  [NUM_CH];
    logic [CNT_W-1:0]  new_phase [NUM_CH];
    logic [CNT_W:0]    diff      [NUM_CH];
    logic [NUM_CH-1:0] mask_act;
    logic [NUM_CH-1:0] mask_sh;
    logic [NUM_CH-1:0] ch_next;
    logic              pending;
    logic              err;
    logic              at_end;
    logic              apply;
    logic              commit_bad;
    logic              addr_bad;

    assign cfg.commit_pending = pending;
    assign cfg.cfg_err        = err;

    // Decide when the shadow set is copied and whether the incoming write is out of range
    always_comb begin
        at_end   = (cnt == period_act - 1'b1);
        apply    = pending && (!run || at_end);
        addr_bad = cfg.cfg_we && (cfg.cfg_addr > MASK_ADDR);
    end

    // Sanitise the shadow set into the values that a commit would make active
    always_comb begin
        commit_bad = 1'b0;
        new_period = period_sh;
        if (period_sh < MIN_P) begin
            new_period = MIN_P;
            commit_bad = 1'b1;
        end
        for (int i = 0; i < NUM_CH; i++) begin
            new_phase[i] = phase_sh[i];
            if (phase_sh[i] >= new_period) begin
                new_phase[i] = '0;
                commit_bad   = 1'b1;
            end
        end
    end

    // Per-channel distance from its phase, wrapped into one period, compared against half a period
    always_comb begin
        ch_next = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (cnt >= phase_act[i]) begin
                diff[i] = {1'b0, cnt} - {1'b0, phase_act[i]};
            end else begin
                diff[i] = {1'b0, cnt} + {1'b0, period_act} - {1'b0, phase_act[i]};
            end
            ch_next[i] = (diff[i] < {1'b0, period_act >> 1}) && mask_act[i] && run;
        end
    end

    // Shared period counter, held at zero while idle
    always_ff @(posedge clk_100MHz or negedge RSTN) begin
        if (!RSTN) begin
            cnt <= '0;
        end else if (!run || at_end) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

    // Shadow register writes, atomic commit into the active set, pending and sticky error flags
    always_ff @(posedge clk_100MHz or negedge RSTN) begin
        if (!RSTN) begin
            period_act <= DEF_P;
            period_sh  <= DEF_P;
            mask_act   <= '1;
            mask_sh    <= '1;
            pending    <= 1'b0;
            err        <= 1'b0;
            for (int i = 0; i < NUM_CH; i++) begin
                phase_act[i] <= '0;
                phase_sh[i]  <= '0;
            end
        end else begin
            if (apply) begin
                period_act <= new_period;
                mask_act   <= mask_sh;
                pending    <= 1'b0;
                for (int i = 0; i < NUM_CH; i++) begin
                    phase_act[i] <= new_phase[i];
                end
            end else if (cfg.cfg_commit) begin
                pending <= 1'b1;
            end

            if (cfg.cfg_we) begin
                if (cfg.cfg_addr == '0) begin
                    period_sh <= cfg.cfg_data[CNT_W-1:0];
                end
                if (cfg.cfg_addr == MASK_ADDR) begin
                    mask_sh <= cfg.cfg_data[NUM_CH-1:0];
                end
                for (int i = 0; i < NUM_CH; i++) begin
                    if (cfg.cfg_addr == ADDR_W'(i + 1)) begin
                        phase_sh[i] <= cfg.cfg_data[CNT_W-1:0];
                    end
                end
            end

            err <= err | addr_bad | (apply & commit_bad);
        end
    end

    // Registered channel outputs and the period-start sync pulse
    always_ff @(posedge clk_100MHz or negedge RSTN) begin
        if (!RSTN) begin
            sync   <= 1'b0;
            ch_out <= '0;
        end else begin
            sync   <= run && (cnt == '0);
            ch_out <= ch_next;
        end
    end

endmodule

// File: tb/tb_phased_array_driver.sv
// Testbench for phased_array_driver: directed configuration sequences with a
// cycle-level behavioural model compared every cycle, plus hand-computed
// literal expectations at chosen counter positions.
module tb_phased_array_driver;

    localparam int NUM_CH     = 10;
    localparam int CNT_W      = 16;
    localparam int DEF_PERIOD = 2500;
    localparam int ADDR_W     = 7;
    localparam int DATA_W     = 16;

    logic              clk_100MHz = 1'b0;
    logic              RSTN;
    logic              run;
    logic              sync;
    logic [NUM_CH-1:0] ch_out;

    int errors = 0;
    int checks = 0;

    phased_array_driver_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) cfg_bus ();

    phased_array_driver #(
        .NUM_CH(NUM_CH), .CNT_W(CNT_W), .DEF_PERIOD(DEF_PERIOD), .ADDR_W(ADDR_W)
    ) dut (
        .clk_100MHz (clk_100MHz),
        .RSTN       (RSTN),
        .run        (run),
        .cfg        (cfg_bus.slave),
        .sync       (sync),
        .ch_out     (ch_out)
    );

    // 100 MHz clock
    always #5 clk_100MHz = ~clk_100MHz;

    // Behavioural model state
    int                m_cnt;
    int                m_p;
    int                sh_p;
    int                m_ph  [NUM_CH];
    int                sh_ph [NUM_CH];
    logic [NUM_CH-1:0] m_mask;
    logic [NUM_CH-1:0] sh_mask;
    logic [NUM_CH-1:0] e_ch;
    logic              e_sync;
    logic              m_pending;
    logic              m_err;

    task automatic check_output(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: square wave = ((cnt - phase) mod P) < P/2, shadow/active register semantics
    always @(posedge clk_100MHz or negedge RSTN) begin
        int d;
        int new_p;
        int a;
        logic do_apply;
        if (!RSTN) begin
            m_cnt = 0; m_p = DEF_PERIOD; sh_p = DEF_PERIOD;
            for (int i = 0; i < NUM_CH; i++) begin m_ph[i] = 0; sh_ph[i] = 0; end
            m_mask = '1; sh_mask = '1; e_ch = '0; e_sync = 1'b0;
            m_pending = 1'b0; m_err = 1'b0;
        end else begin
            for (int i = 0; i < NUM_CH; i++) begin
                d = (m_cnt - m_ph[i] + m_p) % m_p;
                e_ch[i] = run && m_mask[i] && (d < m_p / 2);
            end
            e_sync = run && (m_cnt == 0);
            do_apply = m_pending && (!run || m_cnt == m_p - 1);
            m_cnt = (!run || m_cnt == m_p - 1) ? 0 : m_cnt + 1;
            if (do_apply) begin
                new_p = (sh_p < 2) ? 2 : sh_p;
                if (sh_p < 2) m_err = 1'b1;
                m_p = new_p;
                for (int i = 0; i < NUM_CH; i++) begin
                    if (sh_ph[i] >= new_p) begin
                        m_ph[i] = 0;
                        m_err = 1'b1;
                    end else begin
                        m_ph[i] = sh_ph[i];
                    end
                end
                m_mask = sh_mask;
                m_pending = 1'b0;
            end else if (cfg_bus.cfg_commit) begin
                m_pending = 1'b1;
            end
            if (cfg_bus.cfg_we) begin
                a = int'(cfg_bus.cfg_addr);
                if (a == 0) sh_p = int'(cfg_bus.cfg_data);
                else if (a <= NUM_CH) sh_ph[a-1] = int'(cfg_bus.cfg_data);
                else if (a == NUM_CH + 1) sh_mask = cfg_bus.cfg_data[NUM_CH-1:0];
                else m_err = 1'b1;
            end
        end
    end

    // Compare DUT against the model every cycle, away from the active edge
    always @(negedge clk_100MHz) begin
        check_output("ch_out", 64'(ch_out), 64'(e_ch));
        check_output("sync", 64'(sync), 64'(e_sync));
        check_output("commit_pending", 64'(cfg_bus.commit_pending), 64'(m_pending));
        check_output("cfg_err", 64'(cfg_bus.cfg_err), 64'(m_err));
    end

    task automatic apply_write(input int addr, input int data);
        @(negedge clk_100MHz);
        cfg_bus.cfg_we   = 1'b1;
        cfg_bus.cfg_addr = ADDR_W'(addr);
        cfg_bus.cfg_data = DATA_W'(data);
        @(negedge clk_100MHz);
        cfg_bus.cfg_we   = 1'b0;
    endtask

    task automatic apply_commit();
        @(negedge clk_100MHz);
        cfg_bus.cfg_commit = 1'b1;
        @(negedge clk_100MHz);
        cfg_bus.cfg_commit = 1'b0;
    endtask

    task automatic wait_cnt(input int target, input int budget);
        for (int k = 0; k < budget; k++) begin
            @(negedge clk_100MHz);
            if (m_cnt == target) return;
        end
        checks++;
        errors++;
        $display("[TB] FAIL wait_cnt: counter %0d not reached, got %0d", target, m_cnt);
    endtask

    task automatic wait_commit(input int budget);
        for (int k = 0; k < budget; k++) begin
            @(negedge clk_100MHz);
            if (!m_pending) return;
        end
        checks++;
        errors++;
        $display("[TB] FAIL wait_commit: pending still %0d expected 0", m_pending);
    endtask

    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog: simulation time %0t exceeded limit", $time);
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        RSTN = 1'b1;
        run  = 1'b0;
        cfg_bus.cfg_we     = 1'b0;
        cfg_bus.cfg_addr   = '0;
        cfg_bus.cfg_data   = '0;
        cfg_bus.cfg_commit = 1'b0;
        #1 RSTN = 1'b0;
        #21 RSTN = 1'b1;

        // Reset state
        @(negedge clk_100MHz);
        check_output("rst_ch", 64'(ch_out), 64'h0);
        check_output("rst_sync", 64'(sync), 64'h0);
        check_output("rst_pending", 64'(cfg_bus.commit_pending), 64'h0);
        check_output("rst_err", 64'(cfg_bus.cfg_err), 64'h0);
        run = 1'b1;

        // Default 2500-cycle period, all channels in phase
        wait_cnt(1, 10);
        check_output("t1_sync_first", 64'(sync), 64'h1);
        check_output("t1_ch_rise", 64'(ch_out), 64'h3FF);
        wait_cnt(1250, 1300);
        check_output("t1_ch_last_high", 64'(ch_out), 64'h3FF);
        wait_cnt(1251, 5);
        check_output("t1_ch_first_low", 64'(ch_out), 64'h0);
        wait_cnt(1, 2600);
        check_output("t1_sync_second", 64'(sync), 64'h1);

        // Period 10 with phases 3 and 7
        apply_write(0, 10);
        apply_write(2, 3);
        apply_write(3, 7);
        apply_commit();
        check_output("t2_pending_set", 64'(cfg_bus.commit_pending), 64'h1);
        wait_commit(2600);
        check_output("t2_pending_clear", 64'(cfg_bus.commit_pending), 64'h0);
        wait_cnt(4, 20);
        check_output("t2_ch_cnt3", 64'(ch_out), 64'h3FB);
        wait_cnt(9, 20);
        check_output("t2_ch_cnt8", 64'(ch_out), 64'h004);

        // Mask channel 0 and use an odd period
        apply_write(NUM_CH + 1, 10'h3FE);
        apply_write(0, 11);
        apply_commit();
        wait_commit(30);
        wait_cnt(3, 20);
        check_output("t3_ch_cnt2", 64'(ch_out), 64'h3F8);
        wait_cnt(7, 20);
        check_output("t3_ch_cnt6", 64'(ch_out), 64'h002);

        // Invalid phase, then invalid period
        apply_write(0, 20);
        apply_write(4, 50);
        apply_commit();
        wait_commit(30);
        check_output("t4_err_phase", 64'(cfg_bus.cfg_err), 64'h1);
        apply_write(0, 1);
        apply_commit();
        wait_commit(40);
        wait_cnt(1, 10);
        check_output("t4_p2_high", 64'(ch_out), 64'h3FE);
        wait_cnt(0, 10);
        check_output("t4_p2_low", 64'(ch_out), 64'h0);

        // Drop run, commit while idle, raise run again
        @(negedge clk_100MHz);
        run = 1'b0;
        @(negedge clk_100MHz);
        @(negedge clk_100MHz);
        check_output("t5_idle_ch", 64'(ch_out), 64'h0);
        check_output("t5_idle_sync", 64'(sync), 64'h0);
        apply_write(0, 10);
        apply_commit();
        check_output("t5_pending_set", 64'(cfg_bus.commit_pending), 64'h1);
        @(negedge clk_100MHz);
        check_output("t5_idle_commit", 64'(cfg_bus.commit_pending), 64'h0);
        run = 1'b1;
        wait_cnt(5, 10);
        check_output("t5_ch_cnt4", 64'(ch_out), 64'h3FA);

        // Reset mid-period with a commit pending
        wait_cnt(1, 20);
        apply_write(0, 30);
        apply_commit();
        check_output("t6_pending_set", 64'(cfg_bus.commit_pending), 64'h1);
        @(negedge clk_100MHz);
        #3 RSTN = 1'b0;
        #1;
        check_output("t6_rst_ch", 64'(ch_out), 64'h0);
        check_output("t6_rst_sync", 64'(sync), 64'h0);
        check_output("t6_rst_pending", 64'(cfg_bus.commit_pending), 64'h0);
        check_output("t6_rst_err", 64'(cfg_bus.cfg_err), 64'h0);
        run = 1'b0;
        @(negedge clk_100MHz);
        @(negedge clk_100MHz);
        #2 RSTN = 1'b1;
        @(negedge clk_100MHz);
        run = 1'b1;
        apply_write(NUM_CH + 2, 0);
        check_output("t6_bad_addr_err", 64'(cfg_bus.cfg_err), 64'h1);
        wait_cnt(1250, 1300);
        check_output("t6_default_high", 64'(ch_out), 64'h3FF);
        wait_cnt(1251, 5);
        check_output("t6_default_low", 64'(ch_out), 64'h0);
        wait_cnt(1, 1300);
        check_output("t6_default_sync", 64'(sync), 64'h1);

        @(negedge clk_100MHz);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
